mdioconf_hst_arb: RTL and testbench
===================================

// Module: mdioconf_hst_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing the 10G MAC host configuration interface
//  (config registers + MDIO master) among N_REQ clients (PCIe MDIO access path,
//  link monitor, stats poller). Each client posts one command. The block serialises
//  commands onto host_*, runs config or MDIO handshake, returns result and error per client.
// PARAMETERS
//  N_REQ         3      number of requesters (2..8)
//  CFG_RD_LAT    2      cycles from config-read drive cycle to valid host_rd_data (1..4)
//  MDIO_TIMEOUT  65535  max cycles in MDIO wait/busy states before error (16-bit counter)
// PORTS
//  host_clk       in   1        single clock for everything
//  host_reset_n   in   1        reset, asynchronous, active-low
//  req_valid      in   N_REQ    client i has command pending; hold fields stable until req_ack[i]
//  req_opcode     in   2*N_REQ  slice i: MAC opcode (cfg: [1]=1 read, 0 write; MDIO: 00 addr, 01 wr, 10 rd-inc, 11 rd)
//  req_addr       in   10*N_REQ slice i: host_addr
//  req_wr_data    in   32*N_REQ slice i: write data (MDIO uses [15:0])
//  req_miim_sel   in   N_REQ    1 = MDIO transaction, 0 = config register access
//  req_ack        out  N_REQ    1-cycle pulse: command latched, client may drop/change fields
//  rsp_valid      out  N_REQ    1-cycle pulse: command of client i complete
//  rsp_data       out  32       read result; held until next rsp_valid
//  rsp_err        out  1        1 = MDIO timeout; qualified by rsp_valid, held like rsp_data
//  host_opcode    out  2        to MAC
//  host_addr      out  10       to MAC
//  host_wr_data   out  32       to MAC
//  host_rd_data   in   32       from MAC
//  host_miim_sel  out  1        to MAC
//  host_req       out  1        to MAC, MDIO request strobe
//  host_miim_rdy  in   1        from MAC, MDIO master idle
// BEHAVIOUR
//  - Reset (async, immediate): bus idle = opcode 2'b11, addr 0, wr_data 0, miim_sel 0, req 0;
//    req_ack/rsp_valid 0, rsp_data 0, rsp_err 0; FSM IDLE; rr pointer last=N_REQ-1.
//  - States: IDLE, CFG, CFG_WAIT, MDIO_WAIT, MDIO_REQ, MDIO_BUSY, DONE.
//  - IDLE, cycle t: any req_valid -> grant first set bit searching last+1, last+2, ... (wrap).
//    req_ack[g]=1 in t. Latch opcode/addr/wr_data/miim_sel. last<=g.
//    -> CFG if miim_sel=0, else MDIO_WAIT. Bus is idle during IDLE.
//  - CFG (t+1): drive opcode, addr, wr_data, miim_sel 0 for exactly one cycle.
//    Write: -> DONE. Read: -> CFG_WAIT. Bus returns idle the next cycle.
//  - CFG_WAIT: count CFG_RD_LAT cycles from the CFG cycle. At that edge capture host_rd_data
//    into rsp_data. -> DONE. Read rsp_valid at t+2+CFG_RD_LAT. Write rsp_valid at t+2, rsp_data 0.
//  - MDIO_WAIT: miim_sel 1, opcode 11. Wait host_miim_rdy=1 -> MDIO_REQ.
//  - MDIO_REQ (1 cycle): drive opcode, addr, wr_data={16'b0,cmd[15:0]}, host_req=1, miim_sel 1.
//    -> MDIO_BUSY.
//  - MDIO_BUSY: host_req 0, other fields held, miim_sel 1. Complete on first host_miim_rdy=1.
//    Opcode 1x: rsp_data={16'b0,host_rd_data[15:0]}; else 0. -> DONE.
//  - Timeout: 16-bit counter cleared on entering MDIO_WAIT, counts in MDIO_WAIT/REQ/BUSY.
//    When it reaches MDIO_TIMEOUT: rsp_err 1, rsp_data 0, -> DONE.
//  - DONE: rsp_valid[g]=1 for one cycle. Bus idle (miim_sel 0). -> IDLE.
//    rsp_err=0 for any non-timeout completion.
//  - Throughput: at most one outstanding command; minimum one IDLE cycle between commands.
//  - Client re-asserting req_valid in its rsp cycle is eligible in the next IDLE,
//    after other pending clients (rr).
//  - req_valid dropped before ack: ignored, nothing issued. Fields may change freely
//    while not granted.
//  - Reset mid-transaction: command discarded, no rsp; after release arbitration restarts
//    at client 0.
// TESTING
//  1 Cfg write, client0: opcode 01, addr 0x240, data 0x1C000000 -> ack at t. Bus carries
//    01/0x240/0x1C000000, miim_sel 0 at t+1 only. rsp_valid[0] at t+2, rsp_err 0.
//  2 Cfg read, CFG_RD_LAT=2, host_rd_data = cycle count -> rsp_data equals value present at
//    t+3; rsp_valid at t+4.
//  3 All 3 clients valid continuously, cfg writes -> ack order 0,1,2,0,1; each rsp precedes
//    the next ack; no client starved.
//  4 MDIO read, client1, opcode 11, addr 0x3E1: miim_rdy low 5 cycles then high ->
//    one-cycle host_req; rdy low 20 cycles, then high with rd_data 0xABCD1234 ->
//    rsp_data 0x00001234, err 0.
//  5 MDIO_TIMEOUT=100, miim_rdy stuck low -> rsp_valid[g] with rsp_err 1, rsp_data 0, 100
//    cycles after MDIO_WAIT entry. Bus idle, next command served normally.
//  6 host_reset_n low during MDIO_BUSY -> host_req 0, miim_sel 0, opcode 11 without clock.
//    No rsp. After release, pending client0 and client2 -> client0 acked first.

Source files
------------

// File: rtl/mdioconf_hst_arb.sv
// rtl/mdioconf_hst_arb.sv - round-robin sequencer sharing the MAC host config/MDIO interface
// Grants one client command at a time, runs a config or MDIO handshake and returns the result.
module mdioconf_hst_arb #(
  parameter int N_REQ        = 3,
  parameter int CFG_RD_LAT   = 2,
  parameter int MDIO_TIMEOUT = 65535
) (
  input  logic                  host_clk,
  input  logic                  host_reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [2*N_REQ-1:0]    req_opcode,
  input  logic [10*N_REQ-1:0]   req_addr,
  input  logic [32*N_REQ-1:0]   req_wr_data,
  input  logic [N_REQ-1:0]      req_miim_sel,
  output logic [N_REQ-1:0]      req_ack,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic [1:0]            host_opcode,
  output logic [9:0]            host_addr,
  output logic [31:0]           host_wr_data,
  input  logic [31:0]           host_rd_data,
  output logic                  host_miim_sel,
  output logic                  host_req,
  input  logic                  host_miim_rdy
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_CFG_WAIT, S_MDIO_WAIT, S_MDIO_REQ, S_MDIO_BUSY, S_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] last, gnt, gnt_idx, cand;
  logic          gnt_found;
  logic [1:0]    sel_opcode, cmd_opcode;
  logic [9:0]    sel_addr, cmd_addr;
  logic [31:0]   sel_wr_data;
  logic          sel_miim;
  logic [15:0]   cmd_mdio_data;
  logic [2:0]    lat_cnt;
  logic [15:0]   to_cnt;
  logic          to_hit;

  // Search starts one past the last granted client so every requester gets a turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last) + k) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_opcode  = 2'b00;
    sel_addr    = '0;
    sel_wr_data = '0;
    sel_miim    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_opcode  = req_opcode[i*2 +: 2];
        sel_addr    = req_addr[i*10 +: 10];
        sel_wr_data = req_wr_data[i*32 +: 32];
        sel_miim    = req_miim_sel[i];
      end
    end
  end

  assign req_ack = (state == S_IDLE && gnt_found && host_reset_n) ? (ONE << gnt_idx) : '0;
  assign to_hit  = ({1'b0, to_cnt} + 17'd1) == 17'(MDIO_TIMEOUT);

  always_ff @(posedge host_clk or negedge host_reset_n) begin
    if (!host_reset_n) begin
      state         <= S_IDLE;
      last          <= IW'(N_REQ - 1);
      gnt           <= '0;
      cmd_opcode    <= 2'b00;
      cmd_addr      <= '0;
      cmd_mdio_data <= '0;
      lat_cnt       <= '0;
      to_cnt        <= '0;
      host_opcode   <= 2'b11;
      host_addr     <= '0;
      host_wr_data  <= '0;
      host_miim_sel <= 1'b0;
      host_req      <= 1'b0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            last          <= gnt_idx;
            gnt           <= gnt_idx;
            cmd_opcode    <= sel_opcode;
            cmd_addr      <= sel_addr;
            cmd_mdio_data <= sel_wr_data[15:0];
            if (sel_miim) begin
              host_miim_sel <= 1'b1;
              to_cnt        <= '0;
              state         <= S_MDIO_WAIT;
            end else begin
              host_opcode  <= sel_opcode;
              host_addr    <= sel_addr;
              host_wr_data <= sel_wr_data;
              state        <= S_CFG;
            end
          end
        end
        S_CFG: begin
          host_opcode  <= 2'b11;
          host_addr    <= '0;
          host_wr_data <= '0;
          if (cmd_opcode[1]) begin
            lat_cnt <= 3'd1;
            state   <= S_CFG_WAIT;
          end else begin
            rsp_valid <= ONE << gnt;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_CFG_WAIT: begin
          if (lat_cnt == 3'(CFG_RD_LAT)) begin
            rsp_valid <= ONE << gnt;
            rsp_data  <= host_rd_data;
            rsp_err   <= 1'b0;
            state     <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        S_MDIO_WAIT, S_MDIO_REQ, S_MDIO_BUSY: begin
          to_cnt <= to_cnt + 16'd1;
          // A completion seen in the same cycle as the timeout still wins in BUSY.
          if (state == S_MDIO_BUSY && host_miim_rdy) begin
            rsp_valid     <= ONE << gnt;
            rsp_data      <= cmd_opcode[1] ? {16'b0, host_rd_data[15:0]} : 32'd0;
            rsp_err       <= 1'b0;
            host_opcode   <= 2'b11;
            host_addr     <= '0;
            host_wr_data  <= '0;
            host_miim_sel <= 1'b0;
            state         <= S_DONE;
          end else if (to_hit) begin
            rsp_valid     <= ONE << gnt;
            rsp_data      <= '0;
            rsp_err       <= 1'b1;
            host_opcode   <= 2'b11;
            host_addr     <= '0;
            host_wr_data  <= '0;
            host_miim_sel <= 1'b0;
            host_req      <= 1'b0;
            state         <= S_DONE;
          end else if (state == S_MDIO_WAIT && host_miim_rdy) begin
            host_opcode  <= cmd_opcode;
            host_addr    <= cmd_addr;
            host_wr_data <= {16'b0, cmd_mdio_data};
            host_req     <= 1'b1;
            state        <= S_MDIO_REQ;
          end else if (state == S_MDIO_REQ) begin
            host_req <= 1'b0;
            state    <= S_MDIO_BUSY;
          end
        end
        S_DONE: begin
          rsp_valid <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdioconf_hst_arb.sv
// tb/tb_mdioconf_hst_arb.sv - directed self-checking bench for mdioconf_hst_arb
// Inputs change 1 time unit after posedge; outputs are checked on the negedge.
module tb_mdioconf_hst_arb;
  logic        host_clk = 1'b0;
  logic        host_reset_n;
  logic [2:0]  req_valid, req_miim_sel;
  logic [5:0]  req_opcode;
  logic [29:0] req_addr;
  logic [95:0] req_wr_data;
  logic [2:0]  req_ack, rsp_valid;
  logic [31:0] rsp_data, host_wr_data, host_rd_data, rd_val, cnt, exp_rd;
  logic        rsp_err, host_miim_sel, host_req, host_miim_rdy, rd_mode;
  logic [1:0]  host_opcode;
  logic [9:0]  host_addr;
  int          n_assert = 0;
  int          n_fail = 0;
  int          order[5] = '{0, 1, 2, 0, 1};

  always #5 host_clk = ~host_clk;
  always @(posedge host_clk) cnt <= cnt + 32'd1;
  assign host_rd_data = rd_mode ? cnt : rd_val;

  mdioconf_hst_arb #(.N_REQ(3), .CFG_RD_LAT(2), .MDIO_TIMEOUT(100)) dut (
    .host_clk(host_clk), .host_reset_n(host_reset_n),
    .req_valid(req_valid), .req_opcode(req_opcode), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .req_miim_sel(req_miim_sel), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .host_opcode(host_opcode), .host_addr(host_addr), .host_wr_data(host_wr_data),
    .host_rd_data(host_rd_data), .host_miim_sel(host_miim_sel), .host_req(host_req),
    .host_miim_rdy(host_miim_rdy)
  );

  task automatic cyc();
    @(posedge host_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge host_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int i, input logic [1:0] op, input logic [9:0] a,
                         input logic [31:0] d, input logic s);
    req_opcode[i*2 +: 2]    = op;
    req_addr[i*10 +: 10]    = a;
    req_wr_data[i*32 +: 32] = d;
    req_miim_sel[i]         = s;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_op"}, 32'(host_opcode), 32'd3);
    chk({tag, "_addr"}, 32'(host_addr), 32'd0);
    chk({tag, "_sel"}, 32'(host_miim_sel), 32'd0);
    chk({tag, "_req"}, 32'(host_req), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cnt = 0; rd_mode = 0; rd_val = 0; host_miim_rdy = 0;
    req_opcode = '0; req_addr = '0; req_wr_data = '0; req_miim_sel = '0;
    host_reset_n = 0; req_valid = 3'b001;
    mid();
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk_idle("rst_bus");
    chk("rst_wd", host_wr_data, 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_rspd", rsp_data, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    req_valid = 3'b000;
    cyc(); host_reset_n = 1;

    // cfg write, client 0
    cyc(); set_cmd(0, 2'b01, 10'h240, 32'h1C000000, 1'b0); req_valid = 3'b001;
    mid(); chk("t1_ack", 32'(req_ack), 32'b001); chk_idle("t1_idle_t");
    cyc(); req_valid = 3'b000;
    mid();
    chk("t1_op", 32'(host_opcode), 32'd1);
    chk("t1_addr", 32'(host_addr), 32'h240);
    chk("t1_wd", host_wr_data, 32'h1C000000);
    chk("t1_sel", 32'(host_miim_sel), 32'd0);
    chk("t1_ack0", 32'(req_ack), 32'd0);
    cyc(); mid();
    chk("t1_rspv", 32'(rsp_valid), 32'b001);
    chk("t1_err", 32'(rsp_err), 32'd0);
    chk("t1_rspd", rsp_data, 32'd0);
    chk_idle("t1_idle_t2");
    cyc(); mid(); chk("t1_rspv_off", 32'(rsp_valid), 32'd0);

    // cfg read, client 2, read data follows the bench cycle counter
    rd_mode = 1;
    cyc(); set_cmd(2, 2'b10, 10'h010, 32'h0, 1'b0); req_valid = 3'b100;
    mid(); chk("t2_ack", 32'(req_ack), 32'b100);
    cyc(); req_valid = 3'b000;
    mid(); chk("t2_op", 32'(host_opcode), 32'd2); chk("t2_addr", 32'(host_addr), 32'h010);
    cyc(); mid(); chk_idle("t2_idle"); chk("t2_rspv_t2", 32'(rsp_valid), 32'd0);
    cyc(); mid(); exp_rd = cnt; chk("t2_rspv_t3", 32'(rsp_valid), 32'd0);
    cyc(); mid();
    chk("t2_rspv", 32'(rsp_valid), 32'b100);
    chk("t2_rspd", rsp_data, exp_rd);
    chk("t2_err", 32'(rsp_err), 32'd0);
    cyc(); mid();
    chk("t2_rspv_off", 32'(rsp_valid), 32'd0);
    chk("t2_hold", rsp_data, exp_rd);
    rd_mode = 0;

    // three clients contending with cfg writes
    for (int i = 0; i < 3; i++) set_cmd(i, 2'b00, 10'h100 + 10'(i), 32'hA0 + 32'(i), 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(); req_valid = 3'b111;
      mid(); chk("t3_ack", 32'(req_ack), 32'(3'b001 << order[k]));
      cyc(); mid();
      chk("t3_addr", 32'(host_addr), 32'h100 + 32'(order[k]));
      chk("t3_wd", host_wr_data, 32'hA0 + 32'(order[k]));
      cyc(); mid();
      chk("t3_rspv", 32'(rsp_valid), 32'(3'b001 << order[k]));
      chk("t3_noack", 32'(req_ack), 32'd0);
    end
    cyc(); req_valid = 3'b000;
    mid(); chk("t3_idle_ack", 32'(req_ack), 32'd0);

    // MDIO read, client 1
    cyc(); set_cmd(1, 2'b11, 10'h3E1, 32'h5555, 1'b1); req_valid = 3'b010;
    mid(); chk("t4_ack", 32'(req_ack), 32'b010);
    cyc(); req_valid = 3'b000;
    mid();
    chk("t4_wait_sel", 32'(host_miim_sel), 32'd1);
    chk("t4_wait_op", 32'(host_opcode), 32'd3);
    chk("t4_wait_req", 32'(host_req), 32'd0);
    for (int i = 0; i < 4; i++) cyc();
    cyc(); host_miim_rdy = 1;
    mid(); chk("t4_req_pre", 32'(host_req), 32'd0);
    cyc(); host_miim_rdy = 0;
    mid();
    chk("t4_req", 32'(host_req), 32'd1);
    chk("t4_op", 32'(host_opcode), 32'd3);
    chk("t4_addr", 32'(host_addr), 32'h3E1);
    chk("t4_wd", host_wr_data, 32'h5555);
    chk("t4_sel", 32'(host_miim_sel), 32'd1);
    cyc(); mid();
    chk("t4_busy_req", 32'(host_req), 32'd0);
    chk("t4_busy_addr", 32'(host_addr), 32'h3E1);
    for (int i = 0; i < 19; i++) cyc();
    mid(); chk("t4_busy_rspv", 32'(rsp_valid), 32'd0);
    cyc(); host_miim_rdy = 1; rd_val = 32'hABCD1234;
    cyc(); host_miim_rdy = 0;
    mid();
    chk("t4_rspv", 32'(rsp_valid), 32'b010);
    chk("t4_rspd", rsp_data, 32'h00001234);
    chk("t4_err", 32'(rsp_err), 32'd0);
    chk_idle("t4_idle");
    cyc(); mid(); chk("t4_rspv_off", 32'(rsp_valid), 32'd0);

    // MDIO timeout, client 0, ready never rises
    cyc(); set_cmd(0, 2'b01, 10'h001, 32'h0F0F, 1'b1); req_valid = 3'b001;
    mid(); chk("t5_ack", 32'(req_ack), 32'b001);
    cyc(); req_valid = 3'b000;
    for (int i = 0; i < 99; i++) cyc();
    mid();
    chk("t5_early", 32'(rsp_valid), 32'd0);
    chk("t5_sel_wait", 32'(host_miim_sel), 32'd1);
    cyc(); mid();
    chk("t5_rspv", 32'(rsp_valid), 32'b001);
    chk("t5_err", 32'(rsp_err), 32'd1);
    chk("t5_rspd", rsp_data, 32'd0);
    chk_idle("t5_idle");
    cyc(); set_cmd(1, 2'b01, 10'h055, 32'hDEAD, 1'b0); req_valid = 3'b010;
    mid(); chk("t5_next_ack", 32'(req_ack), 32'b010);
    cyc(); req_valid = 3'b000;
    mid(); chk("t5_next_addr", 32'(host_addr), 32'h055);
    cyc(); mid();
    chk("t5_next_rspv", 32'(rsp_valid), 32'b010);
    chk("t5_next_err", 32'(rsp_err), 32'd0);

    // reset during MDIO_BUSY
    cyc(); set_cmd(2, 2'b01, 10'h022, 32'h1234, 1'b1); req_valid = 3'b100;
    mid(); chk("t6_ack", 32'(req_ack), 32'b100);
    cyc(); host_miim_rdy = 1; set_cmd(0, 2'b01, 10'h011, 32'h7, 1'b0); req_valid = 3'b101;
    cyc(); host_miim_rdy = 0;
    mid(); chk("t6_req", 32'(host_req), 32'd1);
    cyc(); mid(); chk("t6_busy_sel", 32'(host_miim_sel), 32'd1);
    #1 host_reset_n = 0;
    #1 chk_idle("t6_async");
    mid();
    chk("t6_rst_rspv", 32'(rsp_valid), 32'd0);
    chk("t6_rst_ack", 32'(req_ack), 32'd0);
    cyc(); host_reset_n = 1;
    mid(); chk("t6_first", 32'(req_ack), 32'b001);
    cyc(); mid(); chk("t6_addr", 32'(host_addr), 32'h011);
    cyc(); mid(); chk("t6_rspv", 32'(rsp_valid), 32'b001);
    cyc(); mid(); chk("t6_second", 32'(req_ack), 32'b100);
    cyc(); req_valid = 3'b000; host_miim_rdy = 1;
    for (int i = 0; i < 6; i++) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
